// File: rtl/fetch_redirect_sequencer_if.sv
// Redirect-source and IF-control bundle between the EX/trap redirect sources
// and the IF-stage PC controller.
interface fetch_redirect_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_stall;
    logic            i_trap_valid;
    logic [XLEN-1:0] i_trap_target;
    logic            i_branch_valid;
    logic [XLEN-1:0] i_branch_target;
    logic            i_predict_valid;
    logic            i_predict_from_buffer;
    logic [XLEN-1:0] i_predict_target;
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_flush_if;
    logic            o_any_holdoff_safe;
    logic            o_prediction_holdoff;
    logic            o_prediction_from_buffer_holdoff;
    logic            o_control_flow_to_halfword_r;

    modport slave (
        input  i_stall, i_trap_valid, i_trap_target, i_branch_valid, i_branch_target,
               i_predict_valid, i_predict_from_buffer, i_predict_target,
        output o_redirect_valid, o_redirect_pc, o_flush_if, o_any_holdoff_safe,
               o_prediction_holdoff, o_prediction_from_buffer_holdoff,
               o_control_flow_to_halfword_r
    );

    modport master (
        output i_stall, i_trap_valid, i_trap_target, i_branch_valid, i_branch_target,
               i_predict_valid, i_predict_from_buffer, i_predict_target,
        input  o_redirect_valid, o_redirect_pc, o_flush_if, o_any_holdoff_safe,
               o_prediction_holdoff, o_prediction_from_buffer_holdoff,
               o_control_flow_to_halfword_r
    );
endinterface

// File: rtl/fetch_redirect_sequencer.sv
// Arbitrates trap/branch/predict redirects and produces the registered holdoff
// and halfword-entry flags that steer the sequential PC increment logic.
module fetch_redirect_sequencer #(
    parameter int XLEN           = 32,
    parameter int HOLDOFF_CYCLES = 2
) (
    input logic                       i_clk,
    input logic                       i_rst_n,
    fetch_redirect_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PRED = 2'd2
    } state_e;

    localparam logic [2:0] CNT_RELOAD = 3'(HOLDOFF_CYCLES - 1);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            hw_q, hw_d;
    logic            from_buf_q, from_buf_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            flush_q, flush_d;
    logic            holdoff_q, holdoff_d;
    logic            pred_holdoff_q, pred_holdoff_d;
    logic            pred_buf_holdoff_q, pred_buf_holdoff_d;
    logic            hw_flag_q, hw_flag_d;

    logic            hard_req;
    logic [XLEN-1:0] hard_target;
    logic            pred_take;

    always_comb begin
        hard_req    = bus.i_trap_valid | bus.i_branch_valid;
        hard_target = bus.i_trap_valid ? bus.i_trap_target : bus.i_branch_target;
        // Predictions are only taken from a settled, unstalled RUN cycle
        pred_take   = bus.i_predict_valid & ~bus.i_stall & (state_q == ST_RUN);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        hw_d             = hw_q;
        from_buf_d       = from_buf_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        hw_flag_d        = hw_flag_q;

        unique case (state_q)
            ST_RUN: begin
                if (hw_flag_q && !bus.i_stall) begin
                    hw_flag_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!bus.i_stall) begin
                    if (cnt_q == 3'd0) begin
                        state_d   = ST_RUN;
                        hw_flag_d = hw_q;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            ST_PRED: begin
                if (!bus.i_stall) begin
                    state_d   = ST_RUN;
                    hw_flag_d = hw_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A new redirect always wins over whatever sequence is in flight
        if (hard_req) begin
            state_d          = ST_HOLD;
            cnt_d            = CNT_RELOAD;
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            redirect_pc_d    = hard_target & ~XLEN'(1);
            hw_d             = hard_target[1];
            hw_flag_d        = 1'b0;
        end else if (pred_take) begin
            state_d          = ST_PRED;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.i_predict_target & ~XLEN'(1);
            hw_d             = bus.i_predict_target[1];
            from_buf_d       = bus.i_predict_from_buffer;
            hw_flag_d        = 1'b0;
        end

        holdoff_d          = (state_d == ST_HOLD);
        pred_holdoff_d     = (state_d == ST_PRED);
        pred_buf_holdoff_d = (state_d == ST_PRED) & from_buf_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q            <= ST_RUN;
            cnt_q              <= 3'd0;
            hw_q               <= 1'b0;
            from_buf_q         <= 1'b0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            flush_q            <= 1'b0;
            holdoff_q          <= 1'b0;
            pred_holdoff_q     <= 1'b0;
            pred_buf_holdoff_q <= 1'b0;
            hw_flag_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            hw_q               <= hw_d;
            from_buf_q         <= from_buf_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            flush_q            <= flush_d;
            holdoff_q          <= holdoff_d;
            pred_holdoff_q     <= pred_holdoff_d;
            pred_buf_holdoff_q <= pred_buf_holdoff_d;
            hw_flag_q          <= hw_flag_d;
        end
    end

    assign bus.o_redirect_valid                 = redirect_valid_q;
    assign bus.o_redirect_pc                    = redirect_pc_q;
    assign bus.o_flush_if                       = flush_q;
    assign bus.o_any_holdoff_safe               = holdoff_q;
    assign bus.o_prediction_holdoff             = pred_holdoff_q;
    assign bus.o_prediction_from_buffer_holdoff = pred_buf_holdoff_q;
    assign bus.o_control_flow_to_halfword_r     = hw_flag_q;

endmodule

// File: tb/tb_fetch_redirect_sequencer.sv
// Randomized and directed bench for fetch_redirect_sequencer against a
// remaining-cycle-count reference model.
module tb_fetch_redirect_sequencer;

    localparam int XLEN = 32;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_redirect_sequencer_if #(.XLEN(XLEN)) bus ();

    fetch_redirect_sequencer #(.XLEN(XLEN), .HOLDOFF_CYCLES(HOLD)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: outputs expected after the most recent edge
    logic [31:0] m_pc;
    logic        m_valid, m_flush, m_pred, m_buf, m_hw, m_flag;
    int          m_hold_rem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic stall,
                        input logic trap, input logic [31:0] tt,
                        input logic br, input logic [31:0] bt,
                        input logic pr, input logic pb, input logic [31:0] pt);
        rst_n                     = rn;
        bus.i_stall               = stall;
        bus.i_trap_valid          = trap;
        bus.i_trap_target         = tt;
        bus.i_branch_valid        = br;
        bus.i_branch_target       = bt;
        bus.i_predict_valid       = pr;
        bus.i_predict_from_buffer = pb;
        bus.i_predict_target      = pt;
        @(posedge clk);
        if (!rn) begin
            m_pc = 32'h0; m_valid = 0; m_flush = 0; m_pred = 0;
            m_buf = 0; m_hw = 0; m_flag = 0; m_hold_rem = 0;
        end else begin
            m_valid = 0;
            m_flush = 0;
            if (trap || br) begin
                m_pc       = (trap ? tt : bt) & ~32'h1;
                m_valid    = 1;
                m_flush    = 1;
                m_hold_rem = HOLD;
                m_pred     = 0;
                m_hw       = m_pc[1];
                m_flag     = 0;
            end else if (m_hold_rem > 0) begin
                if (!stall) begin
                    m_hold_rem--;
                    if (m_hold_rem == 0) m_flag = m_hw;
                end
            end else if (m_pred) begin
                if (!stall) begin
                    m_pred = 0;
                    m_flag = m_hw;
                end
            end else if (pr && !stall) begin
                m_pc    = pt & ~32'h1;
                m_valid = 1;
                m_pred  = 1;
                m_buf   = pb;
                m_hw    = m_pc[1];
                m_flag  = 0;
            end else if (!stall) begin
                m_flag = 0;
            end
        end
        #1;
        check("redirect_valid", 32'(bus.o_redirect_valid), 32'(m_valid));
        check("redirect_pc", bus.o_redirect_pc, m_pc);
        check("flush_if", 32'(bus.o_flush_if), 32'(m_flush));
        check("holdoff", 32'(bus.o_any_holdoff_safe), 32'(m_hold_rem > 0));
        check("pred_holdoff", 32'(bus.o_prediction_holdoff), 32'(m_pred));
        check("pred_buf_holdoff", 32'(bus.o_prediction_from_buffer_holdoff), 32'(m_pred & m_buf));
        check("halfword_r", 32'(bus.o_control_flow_to_halfword_r), 32'(m_flag));
    endtask

    task automatic idle(input logic stall);
        step(1, stall, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int hc;
        // Reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h1234, 0, 0, 1, 0, 32'h88);
        check("reset_valid", 32'(bus.o_redirect_valid), 32'h0);
        check("reset_pc", bus.o_redirect_pc, 32'h0);
        idle(0); idle(0);

        // Branch to a halfword target
        step(1, 0, 0, 0, 1, 32'h0000_1002, 0, 0, 0);
        check("tp1_pc", bus.o_redirect_pc, 32'h1002);
        check("tp1_flush", 32'(bus.o_flush_if), 32'h1);
        idle(0);
        check("tp1_hold2", 32'(bus.o_any_holdoff_safe), 32'h1);
        idle(0);
        check("tp1_hw", 32'(bus.o_control_flow_to_halfword_r), 32'h1);
        idle(0);
        check("tp1_hw_clr", 32'(bus.o_control_flow_to_halfword_r), 32'h0);

        // Simultaneous sources
        step(1, 0, 1, 32'h8000_0000, 1, 32'h100, 1, 0, 32'h200);
        check("tp2_pc", bus.o_redirect_pc, 32'h8000_0000);
        check("tp2_no_pred", 32'(bus.o_prediction_holdoff), 32'h0);
        idle(0); idle(0); idle(0);

        // Prediction from buffer
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0406);
        check("tp3_buf", 32'(bus.o_prediction_from_buffer_holdoff), 32'h1);
        check("tp3_noflush", 32'(bus.o_flush_if), 32'h0);
        idle(0);
        check("tp3_hw", 32'(bus.o_control_flow_to_halfword_r), 32'h1);
        idle(0);

        // Back-to-back branches
        step(1, 0, 0, 0, 1, 32'h40, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h82, 0, 0, 0);
        check("tp4_pc", bus.o_redirect_pc, 32'h82);
        idle(0); idle(0);
        check("tp4_hw", 32'(bus.o_control_flow_to_halfword_r), 32'h1);
        idle(0);

        // Stall during HOLD stretches the holdoff window
        hc = 0;
        step(1, 0, 0, 0, 1, 32'h12, 0, 0, 0);
        if (bus.o_any_holdoff_safe) hc++;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (bus.o_any_holdoff_safe) hc++;
        end
        for (int i = 0; i < 3; i++) begin
            idle(0);
            if (bus.o_any_holdoff_safe) hc++;
        end
        check("tp5_hold_len", hc, 5);
        idle(0);

        // Reset mid-HOLD, then a predict after release
        step(1, 0, 0, 0, 1, 32'h300, 0, 0, 0);
        step(0, 0, 1, 32'h444, 0, 0, 0, 0, 0);
        check("tp6_rst_hold", 32'(bus.o_any_holdoff_safe), 32'h0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h500);
        check("tp6_pred_valid", 32'(bus.o_redirect_valid), 32'h1);
        idle(0); idle(0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 15) == 0), $urandom(),
                 ($urandom_range(0, 7) == 0), $urandom(),
                 ($urandom_range(0, 3) == 0), 1'($urandom()), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_sequencer.md
# fetch_redirect_sequencer

Sequences the IF-stage holdoff and redirect control that drives the sequential PC increment datapath. It accepts trap, EX-stage branch/jump and IF-stage prediction redirects, arbitrates them by fixed priority, and publishes the redirect PC. It then generates the registered holdoff, prediction-holdoff and halfword-entry flags that the PC increment logic consumes while BRAM fetch data is stale. It sits between the EX/trap redirect sources and the IF-stage PC controller.

## Interface
- XLEN, 32, datapath width
- HOLDOFF_CYCLES, 2, stale-fetch cycles after a trap/branch redirect (BRAM latency); legal range 1..7
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_stall  input  1  IF stall; freezes holdoff countdown and halfword flag
- i_trap_valid  input  1  trap/mret redirect request
- i_trap_target  input  XLEN  trap target PC
- i_branch_valid  input  1  EX taken-branch/jump or mispredict correction
- i_branch_target  input  XLEN  branch target PC
- i_predict_valid  input  1  IF-stage predicted-taken redirect
- i_predict_from_buffer  input  1  prediction sourced from the RAS/instruction buffer
- i_predict_target  input  XLEN  predicted target PC
- o_redirect_valid  output  1  one-cycle pulse: load o_redirect_pc into PC
- o_redirect_pc  output  XLEN  selected target, bit 0 forced to 0
- o_flush_if  output  1  kill IF/ID contents (trap or branch only)
- o_any_holdoff_safe  output  1  registered holdoff flag (HOLD state)
- o_prediction_holdoff  output  1  stale cycle after a prediction
- o_prediction_from_buffer_holdoff  output  1  as above, prediction came from buffer
- o_control_flow_to_halfword_r  output  1  first live cycle after a redirect to a PC with bit 1 set

## Operation
- All outputs are registered. Reset value of every output is 0; o_redirect_pc resets to 0. The state resets to RUN.
- Source priority: trap > branch > predict. A lower-priority request in the same cycle is dropped, not queued.
- States: RUN, HOLD, PRED.
- RUN:
  - On trap or branch: load target, pulse o_redirect_valid and o_flush_if, latch hw = target[1], set cnt = HOLDOFF_CYCLES-1, go to HOLD.
  - Else on predict with !i_stall: load target, pulse o_redirect_valid (no flush), latch hw and from_buf, go to PRED.
  - Predict while stalled is ignored; the source re-presents it.
- HOLD:
  - o_any_holdoff_safe = 1.
  - If !i_stall: cnt==0 → RUN, otherwise cnt decrements.
  - Trap/branch in HOLD restarts the sequence: new target, new pulse, cnt reload.
  - Predict in HOLD is ignored.
- PRED:
  - o_prediction_holdoff = 1; o_prediction_from_buffer_holdoff = from_buf.
  - Lasts exactly one unstalled cycle, then RUN.
  - Trap/branch in PRED preempts: behaves as from RUN, going to HOLD.
- Halfword flag:
  - On the cycle that the HOLD→RUN or PRED→RUN transition takes effect, o_control_flow_to_halfword_r = hw for one unstalled RUN cycle. It is held across stalls, then cleared.
  - A new redirect in that cycle clears it in favour of the new sequence.
- o_any_holdoff_safe and o_prediction_holdoff are never high together.

## Timing
- Request in cycle N → o_redirect_valid, o_redirect_pc and o_flush_if visible in N+1 for exactly one cycle. o_redirect_pc holds its value until the next redirect.
- Trap/branch with no stall:
  - o_any_holdoff_safe is high in cycles N+1..N+HOLDOFF_CYCLES.
  - The halfword flag (if hw) is high in N+HOLDOFF_CYCLES+1.
- Predict with no stall: o_prediction_holdoff is high in N+1; the halfword flag (if hw) is high in N+2.
- Each stalled cycle extends the active holdoff/flag by one cycle.
- Trap/branch is accepted regardless of i_stall.
- Reset low mid-sequence: next cycle all outputs are 0 and state is RUN; requests present during reset are ignored.

## Test plan
- Reset, then branch at cycle 5 to 0x0000_1002 (HOLDOFF_CYCLES=2):
  - o_redirect_valid and o_flush_if are high at cycle 6, with o_redirect_pc = 0x1002.
  - Holdoff is high at cycles 6–7.
  - control_flow_to_halfword_r is high at cycle 8 only.
- Simultaneous trap 0x8000_0000, branch 0x100 and predict 0x200:
  - o_redirect_pc = 0x8000_0000 with a flush.
  - No prediction holdoff is generated.
- Predict from buffer to 0x0000_0406:
  - At N+1: redirect pulse, no flush, prediction_holdoff = 1 and from_buffer_holdoff = 1.
  - halfword_r is high at N+2.
- Branch to 0x40, then a second branch to 0x82 during the first HOLD cycle:
  - Second redirect pulse.
  - Holdoff extends to 2 cycles after the second pulse.
  - halfword_r is high afterwards.
- Branch to 0x12 with i_stall high for 3 cycles during HOLD:
  - Holdoff is high for 5 cycles.
  - halfword_r persists through any stall and is cleared after 1 unstalled cycle.
- Assert i_rst_n low during HOLD:
  - All outputs are 0 next cycle.
  - A predict issued after release is accepted normally.
